divider_seq: RTL and testbench
==============================

# divider_seq

Parametrised, multi-cycle restoring divider with valid/ready handshakes on both sides. It supports unsigned and signed (two's-complement) operation selected per operation. It also resolves divide-by-zero and signed overflow in a single cycle. It replaces the fully unrolled 32-stage combinational divider where area matters more than latency, and sits behind an issuing unit (execute stage or accelerator sequencer) that holds one outstanding division at a time.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- BITS_PER_CYCLE, 1, restoring iterations per clock; must divide WIDTH (1, 2, 4, 8 legal).

Ports:
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  divider can accept a request.
- i_dividend  input  WIDTH  dividend.
- i_divisor  input  WIDTH  divisor.
- i_signed  input  1  1 = signed operands/results, 0 = unsigned.
- o_valid  output  1  result valid.
- i_ready  input  1  consumer accepts result.
- o_quotient  output  WIDTH  quotient.
- o_remainder  output  WIDTH  remainder.
- o_div_by_zero  output  1  result is from a zero divisor (qualified by o_valid).

## Operation
- One clock (i_clk); synchronous active-low reset (i_rst_n).
- FSM states: IDLE, CALC, DONE.
- o_ready = (state == IDLE). o_valid = (state == DONE).
- Accept occurs on an edge with i_valid && o_ready. At accept, i_dividend, i_divisor and i_signed are captured. Later input changes are ignored until the next accept.
- Classification at accept:
  - If divisor == 0: go IDLE→DONE. o_quotient = all ones, o_remainder = dividend as given, o_div_by_zero = 1. This applies in both modes.
  - Else if i_signed && dividend == 2^(WIDTH-1) && divisor == all ones: go IDLE→DONE. o_quotient = dividend, o_remainder = 0, o_div_by_zero = 0.
  - Else: go IDLE→CALC. Store the magnitudes of both operands; in signed mode, negate negative operands. Record the quotient sign (sign xor) and the remainder sign (dividend sign). Load the iteration counter with N = WIDTH/BITS_PER_CYCLE.
- CALC datapath:
  - Each edge performs BITS_PER_CYCLE chained restoring steps, MSB first.
  - Each step: shift the partial remainder left and bring in the next dividend bit. Trial-subtract the divisor using a WIDTH+1-bit subtractor. If there is no borrow, keep the difference and set the quotient bit to 1; otherwise keep the remainder and set the quotient bit to 0.
  - The counter decrements each edge. On the edge where the counter is 1, go CALC→DONE.
  - On that same edge, load o_quotient and o_remainder with sign correction applied. Negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set. The result truncates toward zero and the remainder takes the dividend's sign.
- DONE:
  - Outputs are held stable while o_valid && !i_ready.
  - On an edge with i_ready, go DONE→IDLE. There is no accept in the same cycle.
- Unsigned mode: operands are not transformed and no sign correction is applied.

## Timing
- Reset: on any edge with i_rst_n = 0, state = IDLE, counter = 0, o_quotient = 0, o_remainder = 0, o_div_by_zero = 0. As a result o_valid = 0 and o_ready = 1 from the next cycle.
- Reset mid-CALC or in DONE abandons the operation. No o_valid is produced and no result is retained.
- Normal latency: o_valid is high in the cycle after N edges past the accept edge. Example: WIDTH = 32, BITS_PER_CYCLE = 1 gives o_valid 32 cycles after accept.
- Zero-divisor and signed-overflow latency: o_valid is high in the cycle after the accept edge (1 cycle).
- Throughput: one operation per N+2 cycles at best (accept, N calc cycles, DONE with i_ready = 1). o_ready returns high in the cycle after the result handshake.
- o_quotient, o_remainder and o_div_by_zero are registered. Their values outside DONE are don't-care but must not toggle in IDLE after reset until the first result loads.

## Test plan
- Unsigned, WIDTH = 32, BITS_PER_CYCLE = 1: 100 / 7 → q = 14, r = 2, o_div_by_zero = 0. o_valid exactly 32 cycles after accept. o_ready low throughout.
- Signed: −7 / 2 (0xFFFFFFF9 / 0x00000002) → q = 0xFFFFFFFD, r = 0xFFFFFFFF. Also 7 / −2 → q = 0xFFFFFFFD, r = 0x00000001. Same operands with i_signed = 0 → q = 0x7FFFFFFC, r = 0x00000001.
- Divide by zero: 0x00001234 / 0 in both modes → q = 0xFFFFFFFF, r = 0x00001234, o_div_by_zero = 1, o_valid 1 cycle after accept.
- Signed overflow: 0x80000000 / 0xFFFFFFFF, i_signed = 1 → q = 0x80000000, r = 0, latency 1.
- BITS_PER_CYCLE = 4: 0xFFFFFFFF / 0x10 unsigned → q = 0x0FFFFFFF, r = 0xF, o_valid 8 cycles after accept. Hold i_ready low for 5 cycles: outputs stable, o_ready low, and operand changes on inputs have no effect.
- Reset mid-op: i_rst_n low for one edge at CALC cycle 10 → next cycle o_valid = 0, o_ready = 1, and no stale result appears. A following request 9 / 3 → q = 3, r = 0 with full latency.

Source files
------------

// File: rtl/divider_seq.sv
// divider_seq: multi-cycle restoring divider with valid/ready handshakes on both sides.
// It divides unsigned or two's-complement signed operands. The mode is chosen per operation.
// Divide-by-zero and signed overflow (most-negative / -1) are resolved in one cycle.
// All other operations take WIDTH/BITS_PER_CYCLE iteration cycles.
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_valid / o_ready         request handshake
//   i_dividend, i_divisor     operands, captured at accept
//   i_signed                  1 = signed operation, 0 = unsigned
//   o_valid / i_ready         result handshake
//   o_quotient, o_remainder   registered results; quotient truncates toward zero,
//                             remainder takes the dividend's sign
//   o_div_by_zero             result came from a zero divisor (qualified by o_valid)
module divider_seq #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_signed,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int unsigned Steps = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CntW  = $clog2(Steps + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;    // remaining dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;  // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  // Classify the request as presented on the inputs.
  logic             dividend_neg, divisor_neg, divisor_zero, overflow;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;

  assign dividend_neg = i_signed & i_dividend[WIDTH-1];
  assign divisor_neg  = i_signed & i_divisor[WIDTH-1];
  assign divisor_zero = (i_divisor == '0);
  assign overflow     = i_signed && (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                        (i_divisor == '1);
  assign dividend_mag = dividend_neg ? -i_dividend : i_dividend;
  assign divisor_mag  = divisor_neg ? -i_divisor : i_divisor;

  // BITS_PER_CYCLE chained restoring steps, MSB first.
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH:0]   step_shift, step_diff;
  logic             step_borrow;

  always_comb begin
    step_rem    = rem_q;
    step_quo    = quo_q;
    step_shift  = '0;
    step_diff   = '0;
    step_borrow = 1'b0;
    for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
      step_shift              = {step_rem, step_quo[WIDTH-1]};
      {step_borrow, step_diff} = {1'b0, step_shift} - {2'b00, dvsr_q};
      step_quo                = {step_quo[WIDTH-2:0], ~step_borrow};
      // Partial remainder stays below the divisor, so the top bit is always zero here.
      step_rem                = step_borrow ? step_shift[WIDTH-1:0] : step_diff[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          if (divisor_zero) begin
            state_d     = StDone;
            quotient_d  = '1;
            remainder_d = i_dividend;
            dbz_d       = 1'b1;
          end else if (overflow) begin
            state_d     = StDone;
            quotient_d  = i_dividend;
            remainder_d = '0;
            dbz_d       = 1'b0;
          end else begin
            state_d = StCalc;
            rem_d   = '0;
            quo_d   = dividend_mag;
            dvsr_d  = divisor_mag;
            q_neg_d = dividend_neg ^ divisor_neg;
            r_neg_d = dividend_neg;
            cnt_d   = CntW'(Steps);
          end
        end
      end
      StCalc: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d     = StDone;
          quotient_d  = q_neg_q ? -step_quo : step_quo;
          remainder_d = r_neg_q ? -step_rem : step_rem;
          dbz_d       = 1'b0;
        end
      end
      StDone: begin
        if (i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign o_ready       = (state_q == StIdle);
  assign o_valid       = (state_q == StDone);
  assign o_quotient    = quotient_q;
  assign o_remainder   = remainder_q;
  assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq. Instance 0 uses BITS_PER_CYCLE=1 and instance 1 uses BITS_PER_CYCLE=4,
// both with WIDTH=32. The expected results come from plain integer division in the
// reference model.
module tb_divider_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid  [2];
  logic         out_ready [2];
  logic [W-1:0] dividend  [2];
  logic [W-1:0] divisor   [2];
  logic         in_signed [2];
  logic         out_valid [2];
  logic         in_ready  [2];
  logic [W-1:0] quotient  [2];
  logic [W-1:0] remainder [2];
  logic         out_dbz   [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  divider_seq #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid[0]), .o_ready(out_ready[0]),
    .i_dividend(dividend[0]), .i_divisor(divisor[0]), .i_signed(in_signed[0]),
    .o_valid(out_valid[0]), .i_ready(in_ready[0]), .o_quotient(quotient[0]),
    .o_remainder(remainder[0]), .o_div_by_zero(out_dbz[0])
  );

  divider_seq #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(in_valid[1]), .o_ready(out_ready[1]),
    .i_dividend(dividend[1]), .i_divisor(divisor[1]), .i_signed(in_signed[1]),
    .o_valid(out_valid[1]), .i_ready(in_ready[1]), .o_quotient(quotient[1]),
    .o_remainder(remainder[1]), .o_div_by_zero(out_dbz[1])
  );

  function automatic int steps(input int sel);
    return (sel == 0) ? 32 : 8;
  endfunction

  // Reference: lat = clock edges after the accept edge before o_valid is seen.
  function automatic void model(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic s, output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z, output int lat);
    longint sa, sb;
    z = 1'b0;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1; lat = 0;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; lat = 0;
    end else if (s) begin
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      q   = W'(sa / sb);
      r   = W'(sa % sb);
      lat = steps(sel);
    end else begin
      q   = a / b;
      r   = a % b;
      lat = steps(sel);
    end
  endfunction

  // Drives a request starting at a falling edge; returns at the falling edge after accept.
  task automatic issue(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, output int acc_cyc);
    in_valid[sel]  = 1'b1;
    dividend[sel]  = a;
    divisor[sel]   = b;
    in_signed[sel] = s;
    @(posedge clk);
    @(negedge clk);
    acc_cyc        = cyc;
    in_valid[sel]  = 1'b0;
    dividend[sel]  = $urandom;
    divisor[sel]   = $urandom;
    in_signed[sel] = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_result(input int sel, output int edges, output bit ready_hi);
    edges    = 0;
    ready_hi = 1'b0;
    while (out_valid[sel] !== 1'b1 && edges < 100) begin
      if (out_ready[sel] === 1'b1) ready_hi = 1'b1;
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic release_result(input int sel);
    in_ready[sel] = 1'b1;
    @(negedge clk);
    in_ready[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_ready[i] = 1'b0; in_signed[i] = 1'b0;
      dividend[i] = '0;   divisor[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (out_ready[i] !== 1'b1 || out_valid[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hs[%0d] ready=%b valid=%b want ready=1 valid=0", i, out_ready[i],
                 out_valid[i]);
      end
      checks++;
      if (quotient[i] !== '0 || remainder[i] !== '0 || out_dbz[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_out[%0d] q=%h r=%h z=%b want 0/0/0", i, quotient[i], remainder[i],
                 out_dbz[i]);
      end
    end
    // Idle with noisy operands but no valid: results must not move.
    repeat (5) begin
      dividend[0] = $urandom; divisor[0] = $urandom;
      @(negedge clk);
    end
    checks++;
    if (quotient[0] !== '0 || remainder[0] !== '0 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL idle_stable q=%h r=%h v=%b want 0/0/0", quotient[0], remainder[0],
               out_valid[0]);
    end
  endtask

  task automatic test_unsigned_basic();
    int  acc, edges;
    bit  rh;
    issue(0, 32'd100, 32'd7, 1'b0, acc);
    wait_result(0, edges, rh);
    checks++;
    if (edges !== 32) begin
      errors++; $display("FAIL u100_7_latency got %0d want 32", edges);
    end
    checks++;
    if (rh) begin
      errors++; $display("FAIL u100_7_ready got ready high during calc want low");
    end
    checks++;
    if (quotient[0] !== 32'd14 || remainder[0] !== 32'd2 || out_dbz[0] !== 1'b0) begin
      errors++;
      $display("FAIL u100_7 got q=%0d r=%0d z=%b want q=14 r=2 z=0", quotient[0], remainder[0],
               out_dbz[0]);
    end
    release_result(0);
    checks++;
    if (out_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL post_handshake got ready=%b valid=%b want 1/0", out_ready[0], out_valid[0]);
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] ta [4] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'hFFFF_FFF9, 32'h0000_0007};
    logic [W-1:0] tb [4] = '{32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0002, 32'hFFFF_FFFE};
    logic         ts [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] tq [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h7FFF_FFFC, 32'h0000_0000};
    logic [W-1:0] tr [4] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 32'h0000_0007};
    int acc, edges;
    bit rh;
    for (int i = 0; i < 4; i++) begin
      issue(0, ta[i], tb[i], ts[i], acc);
      wait_result(0, edges, rh);
      checks++;
      if (edges !== 32 || quotient[0] !== tq[i] || remainder[0] !== tr[i]) begin
        errors++;
        $display("FAIL signed_case%0d got q=%h r=%h lat=%0d want q=%h r=%h lat=32", i,
                 quotient[0], remainder[0], edges, tq[i], tr[i]);
      end
      release_result(0);
    end
  endtask

  task automatic test_div_by_zero();
    int acc, edges;
    bit rh;
    for (int sel = 0; sel < 2; sel++) begin
      for (int s = 0; s < 2; s++) begin
        issue(sel, 32'h0000_1234, 32'h0, 1'(s), acc);
        wait_result(sel, edges, rh);
        checks++;
        if (edges !== 0 || quotient[sel] !== 32'hFFFF_FFFF || remainder[sel] !== 32'h1234 ||
            out_dbz[sel] !== 1'b1) begin
          errors++;
          $display("FAIL dbz[%0d,s=%0d] got q=%h r=%h z=%b lat=%0d want q=ffffffff r=1234 z=1 lat=0",
                   sel, s, quotient[sel], remainder[sel], out_dbz[sel], edges);
        end
        release_result(sel);
      end
    end
  endtask

  task automatic test_overflow();
    int acc, edges;
    bit rh;
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, acc);
    wait_result(0, edges, rh);
    checks++;
    if (edges !== 0 || quotient[0] !== 32'h8000_0000 || remainder[0] !== '0 ||
        out_dbz[0] !== 1'b0) begin
      errors++;
      $display("FAIL overflow got q=%h r=%h z=%b lat=%0d want q=80000000 r=0 z=0 lat=0",
               quotient[0], remainder[0], out_dbz[0], edges);
    end
    release_result(0);
    // Same operands unsigned is an ordinary division.
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, acc);
    wait_result(0, edges, rh);
    checks++;
    if (edges !== 32 || quotient[0] !== '0 || remainder[0] !== 32'h8000_0000) begin
      errors++;
      $display("FAIL overflow_unsigned got q=%h r=%h lat=%0d want q=0 r=80000000 lat=32",
               quotient[0], remainder[0], edges);
    end
    release_result(0);
  endtask

  task automatic test_hold_bpc4();
    int           acc, edges;
    bit           rh;
    logic [W-1:0] q0, r0;
    issue(1, 32'hFFFF_FFFF, 32'h10, 1'b0, acc);
    wait_result(1, edges, rh);
    checks++;
    if (edges !== 8 || quotient[1] !== 32'h0FFF_FFFF || remainder[1] !== 32'hF) begin
      errors++;
      $display("FAIL bpc4 got q=%h r=%h lat=%0d want q=0fffffff r=f lat=8", quotient[1],
               remainder[1], edges);
    end
    q0 = quotient[1];
    r0 = remainder[1];
    for (int i = 0; i < 5; i++) begin
      in_valid[1]  = 1'b1;
      dividend[1]  = $urandom;
      divisor[1]   = $urandom;
      in_signed[1] = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (out_valid[1] !== 1'b1 || out_ready[1] !== 1'b0 || quotient[1] !== q0 ||
          remainder[1] !== r0) begin
        errors++;
        $display("FAIL hold%0d got v=%b rdy=%b q=%h r=%h want v=1 rdy=0 q=%h r=%h", i,
                 out_valid[1], out_ready[1], quotient[1], remainder[1], q0, r0);
      end
    end
    in_valid[1] = 1'b0;
    release_result(1);
    checks++;
    if (out_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got ready=%b valid=%b want 1/0", out_ready[1], out_valid[1]);
    end
  endtask

  task automatic test_reset_mid_op();
    int acc, edges, seen;
    bit rh;
    issue(0, 32'd100, 32'd7, 1'b0, acc);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (out_valid[0] !== 1'b0 || out_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got valid=%b ready=%b want 0/1", out_valid[0], out_ready[0]);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_stale got %0d valid cycles want 0", seen);
    end
    issue(0, 32'd9, 32'd3, 1'b0, acc);
    wait_result(0, edges, rh);
    checks++;
    if (edges !== 32 || quotient[0] !== 32'd3 || remainder[0] !== '0) begin
      errors++;
      $display("FAIL after_reset got q=%0d r=%0d lat=%0d want q=3 r=0 lat=32", quotient[0],
               remainder[0], edges);
    end
    release_result(0);
  endtask

  task automatic test_back_to_back();
    int           acc_a, acc_b, edges;
    bit           rh;
    logic [W-1:0] eq, er;
    logic         ez;
    int           el;
    in_ready[1] = 1'b1;
    issue(1, 32'd1000, 32'd33, 1'b0, acc_a);
    wait_result(1, edges, rh);
    checks++;
    if (edges !== 8 || quotient[1] !== 32'd30 || remainder[1] !== 32'd10) begin
      errors++;
      $display("FAIL b2b_first got q=%0d r=%0d lat=%0d want q=30 r=10 lat=8", quotient[1],
               remainder[1], edges);
    end
    @(negedge clk);
    checks++;
    if (out_ready[1] !== 1'b1) begin
      errors++; $display("FAIL b2b_ready got %b want 1", out_ready[1]);
    end
    issue(1, 32'hFFFF_FF00, 32'h0000_0013, 1'b1, acc_b);
    checks++;
    if (acc_b - acc_a !== 10) begin
      errors++; $display("FAIL b2b_throughput got %0d cycles want 10", acc_b - acc_a);
    end
    model(1, 32'hFFFF_FF00, 32'h0000_0013, 1'b1, eq, er, ez, el);
    wait_result(1, edges, rh);
    checks++;
    if (edges !== el || quotient[1] !== eq || remainder[1] !== er) begin
      errors++;
      $display("FAIL b2b_second got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d", quotient[1],
               remainder[1], edges, eq, er, el);
    end
    @(negedge clk);
    in_ready[1] = 1'b0;
  endtask

  task automatic test_random();
    int           sel, acc, edges, el;
    bit           rh;
    logic [W-1:0] a, b, eq, er;
    logic         s, ez;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 1);
      s   = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = '1; end
        2: b = W'($urandom_range(1, 15));
        3: b = -W'($urandom_range(1, 255));
        4: a = W'($urandom_range(0, 1000));
        5: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      model(sel, a, b, s, eq, er, ez, el);
      issue(sel, a, b, s, acc);
      wait_result(sel, edges, rh);
      checks++;
      if (edges !== el || quotient[sel] !== eq || remainder[sel] !== er ||
          out_dbz[sel] !== ez) begin
        errors++;
        $display("FAIL rand%0d[%0d] %h/%h s=%b got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                 n, sel, a, b, s, quotient[sel], remainder[sel], out_dbz[sel], edges, eq, er,
                 ez, el);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_result(sel);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_hold_bpc4();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
